panda_if_fetch: RTL and testbench

Instruction fetch stage of the Panda core. Owns the fetch address and issues word requests to instruction memory over a request/grant/response-valid handshake. Buffers returned instructions with their PCs in a small FIFO for the decode stage. On a taken branch or jump from execute, flushes in-flight work and redirects fetch to the target address.

---
 rtl/panda_if_fetch_if.sv | 33 +++
 rtl/panda_if_fetch.sv | 116 +++++++++++
 tb/tb_panda_if_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/panda_if_fetch_if.sv
// ---------------------------------------------------------------------------
// panda_if_fetch_if : memory-side and decode-side buses of the fetch stage
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface panda_if_fetch_if #(
   parameter int unsigned WIDTH = 32
);
   logic             flush;
   logic [WIDTH-1:0] flush_addr;
   logic             req;
   logic [WIDTH-1:0] addr;
   logic             gnt;
   logic             rvalid;
   logic [WIDTH-1:0] rdata;
   logic             valid;
   logic [WIDTH-1:0] instr;
   logic [WIDTH-1:0] pc;
   logic             ready;

   modport master (
      input  flush, flush_addr, gnt, rvalid, rdata, ready,
      output req, addr, valid, instr, pc
   );

   modport slave (
      output flush, flush_addr, gnt, rvalid, rdata, ready,
      input  req, addr, valid, instr, pc
   );
endinterface

`default_nettype wire

// File: rtl/panda_if_fetch.sv
// ---------------------------------------------------------------------------
// panda_if_fetch : instruction fetch with one outstanding request and FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module panda_if_fetch #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      DEPTH      = 2,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   panda_if_fetch_if.master bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_OCC = DEPTH[CNT_W:0];
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] fetch_addr_q;
   logic [WIDTH-1:0] pend_pc_q;
   logic             out_q;
   logic             discard_q;
   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [WIDTH-1:0] instr_mem_q [DEPTH];
   logic [WIDTH-1:0] pc_mem_q    [DEPTH];

   logic [CNT_W:0]   occupancy;
   logic             req;
   logic             grant;
   logic             resp;
   logic             push;
   logic             pop;
   logic             head_valid;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Space check counts the in-flight request but ignores a same-cycle pop.
   assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, out_q};
   assign req        = rst_ni && !bus.flush && (!out_q || bus.rvalid)
                       && (occupancy < DEPTH_OCC);
   assign grant      = req && bus.gnt;
   assign resp       = bus.rvalid && out_q;
   assign push       = resp && !discard_q && !bus.flush;
   assign head_valid = (count_q != '0);
   assign pop        = head_valid && bus.ready;

   assign bus.req   = req;
   assign bus.addr  = fetch_addr_q;
   assign bus.valid = head_valid;
   assign bus.instr = instr_mem_q[rd_ptr_q];
   assign bus.pc    = pc_mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_addr_q <= RESET_ADDR;
         pend_pc_q    <= '0;
         out_q        <= 1'b0;
         discard_q    <= 1'b0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i]    <= '0;
         end
      end else begin
         if (bus.flush) begin
            fetch_addr_q <= {bus.flush_addr[WIDTH-1:2], 2'b00};
         end else if (grant) begin
            fetch_addr_q <= fetch_addr_q + WIDTH'(4);
         end

         if (grant) begin
            out_q     <= 1'b1;
            pend_pc_q <= fetch_addr_q;
         end else if (resp) begin
            out_q <= 1'b0;
         end

         // A response still in flight at flush time must be dropped on arrival.
         if (resp) begin
            discard_q <= 1'b0;
         end else if (bus.flush && out_q) begin
            discard_q <= 1'b1;
         end

         if (bus.flush) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) begin
               instr_mem_q[wr_ptr_q] <= bus.rdata;
               pc_mem_q[wr_ptr_q]    <= pend_pc_q;
               wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
               rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
               count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
               count_q <= count_q - CNT_W'(1);
            end
         end
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_panda_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_panda_if_fetch : cycle-by-cycle vector table for the fetch stage
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_panda_if_fetch;
   localparam logic [31:0] D = 32'h1000_0000;

   typedef struct {
      logic        flush;
      logic [31:0] faddr;
      logic        gnt;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] einstr;
      logic [31:0] epc;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_fail;
   vec_t vecs[$];

   panda_if_fetch_if #(.WIDTH(32)) bus ();

   panda_if_fetch #(
      .WIDTH(32),
      .DEPTH(2),
      .RESET_ADDR(32'h0000_0000)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic f, input logic [31:0] fa, input logic g,
                      input logic rv, input logic [31:0] rd, input logic rdy,
                      input logic ereq, input logic [31:0] eaddr,
                      input logic evalid, input logic [31:0] einstr,
                      input logic [31:0] epc);
      vec_t v;
      v.flush = f;  v.faddr = fa; v.gnt = g; v.rv = rv; v.rdata = rd;
      v.rdy = rdy;  v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid;
      v.einstr = einstr; v.epc = epc;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic f, input logic [31:0] fa, input logic g,
                        input logic rv, input logic [31:0] rd, input logic rdy);
      bus.flush = f; bus.flush_addr = fa; bus.gnt = g;
      bus.rvalid = rv; bus.rdata = rd; bus.ready = rdy;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

      //   flush faddr        gnt rv rdata         rdy  req addr          vld instr          pc
      add(0, 32'h0,         1, 0, 32'h0,        1,   1, 32'h0,         0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 1, D+32'h0,      1,   1, 32'h4,         0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 1, D+32'h4,      1,   0, 32'h8,         1, D+32'h0,       32'h0);
      add(0, 32'h0,         1, 0, 32'h0,        1,   1, 32'h8,         1, D+32'h4,       32'h4);
      add(0, 32'h0,         1, 1, D+32'h8,      1,   1, 32'hC,         0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 1, D+32'hC,      1,   0, 32'h10,        1, D+32'h8,       32'h8);
      add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h10,        1, D+32'hC,       32'hC);
      add(0, 32'h0,         1, 1, D+32'h10,     0,   0, 32'h14,        1, D+32'hC,       32'hC);
      add(0, 32'h0,         1, 0, 32'h0,        0,   0, 32'h14,        1, D+32'hC,       32'hC);
      add(0, 32'h0,         1, 0, 32'h0,        0,   0, 32'h14,        1, D+32'hC,       32'hC);
      add(0, 32'h0,         1, 0, 32'h0,        1,   0, 32'h14,        1, D+32'hC,       32'hC);
      add(0, 32'h0,         1, 0, 32'h0,        1,   1, 32'h14,        1, D+32'h10,      32'h10);
      // redirect to 0x103 while 0x14 is outstanding
      add(1, 32'h103,       1, 0, 32'h0,        1,   0, 32'h18,        0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 0, 32'h0,        1,   0, 32'h100,       0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 1, 32'hDEAD0014, 1,   1, 32'h100,       0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 1, D+32'h100,    1,   1, 32'h104,       0, 32'h0,         32'h0);
      // flush together with rvalid and a pop
      add(1, 32'h200,       1, 1, D+32'h104,    1,   0, 32'h108,       1, D+32'h100,     32'h100);
      // grant held off for three cycles
      add(0, 32'h0,         0, 0, 32'h0,        1,   1, 32'h200,       0, 32'h0,         32'h0);
      add(0, 32'h0,         0, 0, 32'h0,        1,   1, 32'h200,       0, 32'h0,         32'h0);
      add(0, 32'h0,         0, 0, 32'h0,        1,   1, 32'h200,       0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 0, 32'h0,        1,   1, 32'h200,       0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 1, D+32'h200,    1,   1, 32'h204,       0, 32'h0,         32'h0);
      add(0, 32'h0,         0, 1, D+32'h204,    1,   0, 32'h208,       1, D+32'h200,     32'h200);
      add(0, 32'h0,         0, 0, 32'h0,        1,   1, 32'h208,       1, D+32'h204,     32'h204);
      // address wrap at the top of the space
      add(1, 32'hFFFFFFFE,  0, 0, 32'h0,        1,   0, 32'h208,       0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 0, 32'h0,        1,   1, 32'hFFFFFFFC,  0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 0, 32'h0,        1,   0, 32'h0,         0, 32'h0,         32'h0);
      add(0, 32'h0,         0, 1, 32'hAAAAFFFC, 1,   1, 32'h0,         0, 32'h0,         32'h0);
      // stray rvalid with nothing outstanding is ignored
      add(0, 32'h0,         0, 1, 32'h00000BAD, 0,   1, 32'h0,         1, 32'hAAAAFFFC,  32'hFFFFFFFC);
      add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h0,         1, 32'hAAAAFFFC,  32'hFFFFFFFC);
      add(0, 32'h0,         0, 0, 32'h0,        1,   0, 32'h4,         1, 32'hAAAAFFFC,  32'hFFFFFFFC);
      add(0, 32'h0,         0, 0, 32'h0,        1,   0, 32'h4,         0, 32'h0,         32'h0);
      add(0, 32'h0,         0, 1, D+32'h0,      1,   1, 32'h4,         0, 32'h0,         32'h0);
      add(0, 32'h0,         1, 0, 32'h0,        0,   1, 32'h4,         1, D+32'h0,       32'h0);

      repeat (2) @(negedge clk);
      #1;
      chk("reset req",   {31'b0, bus.req},   32'h0);
      chk("reset addr",  bus.addr,           32'h0);
      chk("reset valid", {31'b0, bus.valid}, 32'h0);
      chk("reset instr", bus.instr,          32'h0);
      chk("reset pc",    bus.pc,             32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].flush, vecs[i].faddr, vecs[i].gnt, vecs[i].rv,
               vecs[i].rdata, vecs[i].rdy);
         #1;
         chk($sformatf("v%0d req", i),   {31'b0, bus.req},   {31'b0, vecs[i].ereq});
         chk($sformatf("v%0d addr", i),  bus.addr,           vecs[i].eaddr);
         chk($sformatf("v%0d valid", i), {31'b0, bus.valid}, {31'b0, vecs[i].evalid});
         if (vecs[i].evalid) begin
            chk($sformatf("v%0d instr", i), bus.instr, vecs[i].einstr);
            chk($sformatf("v%0d pc", i),    bus.pc,    vecs[i].epc);
         end
         @(negedge clk);
      end

      // Request for 0x4 outstanding with one entry buffered; reset mid-request.
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk("pre-rst req",   {31'b0, bus.req},   32'h0);
      chk("pre-rst valid", {31'b0, bus.valid}, 32'h1);
      chk("pre-rst addr",  bus.addr,           32'h8);
      rst_n = 1'b0;
      #1;
      chk("async rst req",   {31'b0, bus.req},   32'h0);
      chk("async rst valid", {31'b0, bus.valid}, 32'h0);
      chk("async rst addr",  bus.addr,           32'h0);
      chk("async rst pc",    bus.pc,             32'h0);
      @(negedge clk);
      // Late response to the pre-reset request arrives right after release.
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD_0004, 1'b1);
      #1;
      chk("post-rst req",  {31'b0, bus.req}, 32'h1);
      chk("post-rst addr", bus.addr,         32'h0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      #1;
      chk("late rsp dropped", {31'b0, bus.valid}, 32'h0);
      chk("late rsp req",     {31'b0, bus.req},   32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
